// File: rtl/raytrace_pkg.sv
// Shared definitions for the ray-tracing frame scheduler: defaults, FSM encoding
// and an index-width helper used by the scheduler and its arbiter.
package raytrace_pkg;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_PIX_W     = 13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest-index requester at or after (ptr + 1) mod NUM_CORES,
// returned both one-hot and as a binary index.
module rr_arbiter
   import raytrace_pkg::*;
#(
   parameter  int NUM_CORES = DEF_NUM_CORES,
   localparam int IDX_W     = idx_width(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_CORES-1:0] grant,
   output logic [IDX_W-1:0]     index,
   output logic                 any
);

   int unsigned          pos;
   logic [IDX_W-1:0]     cand;

   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      pos   = 0;
      cand  = '0;
      // Walk one full lap starting just past the last grant; first hit wins.
      for (int i = 1; i <= NUM_CORES; i++) begin
         pos  = (int'(ptr) + i) % NUM_CORES;
         cand = IDX_W'(pos);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/ray_scheduler.sv
// Frame scheduler: walks the image in raster order and hands each pixel to a
// free tracer core (round-robin), tracking completions until the frame drains.
module ray_scheduler
   import raytrace_pkg::*;
#(
   parameter  int NUM_CORES = DEF_NUM_CORES,
   parameter  int PIX_W     = DEF_PIX_W,
   localparam int CORE_W    = idx_width(NUM_CORES)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [PIX_W-1:0]     image_width,
   input  logic [PIX_W-1:0]     image_height,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [PIX_W-1:0]     pix_x,
   output logic [PIX_W-1:0]     pix_y,
   output logic [CORE_W-1:0]    pix_core,
   input  logic [NUM_CORES-1:0] core_done,
   output logic                 busy,
   output logic                 frame_done,
   output logic [2*PIX_W-1:0]   rays_retired
);

   localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);

   function automatic logic [2*PIX_W-1:0] popcount(input logic [NUM_CORES-1:0] v);
      popcount = '0;
      for (int i = 0; i < NUM_CORES; i++)
         popcount = popcount + {{(2*PIX_W-1){1'b0}}, v[i]};
   endfunction

   sched_state_t         state, state_nxt;
   logic [NUM_CORES-1:0] free_map, done_mask, grant;
   logic [CORE_W-1:0]    rr_ptr, grant_idx;
   logic                 grant_any;
   logic [PIX_W-1:0]     width_lat, height_lat, x_cnt, y_cnt;
   logic                 all_issued;
   logic                 start_acc, size_zero, load, hshake, last_load, last_hshake;

   rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
      .req   (free_map),
      .ptr   (rr_ptr),
      .grant (grant),
      .index (grant_idx),
      .any   (grant_any)
   );

   // Completions on cores already marked free are stale and must not count.
   assign done_mask   = core_done & ~free_map;
   assign start_acc   = (state == ST_IDLE) && start;
   assign size_zero   = (image_width == '0) || (image_height == '0);
   assign hshake      = pix_valid && pix_ready;
   assign load        = (state == ST_ISSUE) && (!pix_valid || pix_ready) &&
                        grant_any && !all_issued;
   assign last_load   = (x_cnt == width_lat - PIX_ONE) && (y_cnt == height_lat - PIX_ONE);
   assign last_hshake = hshake && (pix_x == width_lat - PIX_ONE) &&
                        (pix_y == height_lat - PIX_ONE);
   assign busy        = (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = size_zero ? ST_DONE : ST_ISSUE;
         ST_ISSUE: if (last_hshake) state_nxt = ST_DRAIN;
         ST_DRAIN: if (&free_map) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Request stage: control state and the registered pixel request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         pix_valid    <= 1'b0;
         pix_x        <= '0;
         pix_y        <= '0;
         pix_core     <= '0;
         free_map     <= '1;
         rr_ptr       <= CORE_W'(NUM_CORES - 1);
         frame_done   <= 1'b0;
         rays_retired <= '0;
         all_issued   <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= (state == ST_DONE);
         free_map   <= (free_map | done_mask) & ~(load ? grant : '0);
         if (start_acc) begin
            rays_retired <= '0;
            all_issued   <= 1'b0;
         end else begin
            rays_retired <= rays_retired + popcount(done_mask);
            if (load && last_load)
               all_issued <= 1'b1;
         end
         if (load) begin
            pix_valid <= 1'b1;
            pix_x     <= x_cnt;
            pix_y     <= y_cnt;
            pix_core  <= grant_idx;
            rr_ptr    <= grant_idx;
         end else if (hshake) begin
            pix_valid <= 1'b0;
         end
      end
   end

   // Raster walk: next pixel to issue; parks on the last pixel rather than wrapping
   always_ff @(posedge clk) begin
      if (start_acc) begin
         width_lat  <= image_width;
         height_lat <= image_height;
         x_cnt      <= '0;
         y_cnt      <= '0;
      end else if (load && !last_load) begin
         if (x_cnt == width_lat - PIX_ONE) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + PIX_ONE;
         end else begin
            x_cnt <= x_cnt + PIX_ONE;
         end
      end
   end

endmodule

// File: doc/ray_scheduler.md
RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_CORES, default 4, number of tracer cores; PIX_W, default 13, pixel coordinate width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse
- image_width  in  PIX_W  pixels per row
- image_height  in  PIX_W  rows per frame
- pix_valid  out  1  pixel request valid
- pix_ready  in  1  ray generator accepts request
- pix_x  out  PIX_W  pixel column
- pix_y  out  PIX_W  pixel row
- pix_core  out  log2(NUM_CORES)  tracer core receiving this ray
- core_done  in  NUM_CORES  one-cycle pulse per core when its ray completes
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the frame completes
- rays_retired  out  2*PIX_W  rays completed in the current frame

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-004 In IDLE, start=1 SHALL latch image_width/image_height, clear x, y and rays_retired, and move to ISSUE; start SHALL be ignored in all other states.
REQ-005 If the latched width or height is 0, IDLE SHALL go directly to DONE with no pixel request issued.
REQ-006 A free bitmap of NUM_CORES bits SHALL be all-ones after reset; a bit SHALL clear when its core is loaded into the request register and SHALL set on core_done for that core.
REQ-007 core_done on a core whose free bit is already set SHALL be ignored and SHALL NOT count.
REQ-008 pix_valid, pix_x, pix_y and pix_core SHALL be registered; once pix_valid=1, they SHALL hold stable until the cycle pix_valid and pix_ready are both 1.
REQ-009 In ISSUE, the request register SHALL load on any cycle it is empty or handshaking, provided a free core exists and pixels remain; pix_valid SHALL be 1 the cycle after load.
REQ-010 Core selection SHALL be round-robin: lowest-index free core at or after (last granted + 1) mod NUM_CORES; the pointer SHALL start at core 0 after reset.
REQ-011 Pixels SHALL issue in raster order: x from 0 to width-1, then x=0 and y+1; back-to-back throughput SHALL be one pixel per cycle while cores are free and pix_ready=1.
REQ-012 After the handshake of pixel (width-1, height-1), ISSUE SHALL go to DRAIN.
REQ-013 A core_done arriving in the same cycle as a load SHALL free its core for selection on the next cycle, not the current one.
REQ-014 DRAIN SHALL go to DONE when all free bits are set.
REQ-015 DONE SHALL assert frame_done for exactly one cycle, then go to IDLE.
REQ-016 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-017 rays_retired SHALL increment on each counted core_done bit; multiple bits in one cycle SHALL add their popcount; it SHALL hold its value in IDLE until the next start.
REQ-018 Arithmetic SHALL be unsigned; pixel counters SHALL be PIX_W bits and SHALL NOT wrap within a frame.

Reset
REQ-019 Assertion of reset_n=0 SHALL, asynchronously and at any point mid-frame, force state=IDLE, pix_valid=0, pix_x=pix_y=0, pix_core=0, busy=0, frame_done=0, rays_retired=0, free bitmap all-ones, and RR pointer=NUM_CORES-1.
REQ-020 In-flight rays at reset SHALL be forgotten; core_done pulses after reset SHALL be ignored under REQ-007.

Structure
REQ-021 The state enum, NUM_CORES and PIX_W defaults SHALL reside in shared package raytrace_pkg.
REQ-022 Round-robin selection SHALL be sub-module rr_arbiter (inputs: request mask, pointer; outputs: one-hot grant, index, any).

Verification
REQ-023 For W=4, H=2 with pix_ready=1 and immediate core_done: 8 requests in order (0,0)..(3,1), pix_core sequence 0,1,2,3,0,1,2,3, rays_retired=8, and one frame_done pulse.
REQ-024 For W=3, H=3 with no core_done until 20 cycles: exactly 4 requests issue, then pix_valid=0; core_done[2] makes the next request go to core 2.
REQ-025 Hold pix_ready=0 for 5 cycles with pix_valid=1: pix_x, pix_y and pix_core must stay constant; a core_done on another core must not change them.
REQ-026 W=0, H=5, then start: frame_done must pulse 2 cycles after start, with no pix_valid.
REQ-027 Assert reset_n=0 in the middle of a 16x16 frame: all outputs must reach reset values immediately; stray core_done must leave rays_retired=0; a new start must restart at (0,0) on core 0.
REQ-028 core_done=4'b1111 in one cycle with all 4 cores busy: rays_retired must increase by 4; a start pulse during ISSUE must be ignored.
